// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 8-digit multiplexed 7-segment display scan controller
//
// Time-multiplexes a 32-bit display register onto an 8-digit common-anode
// display through one shared hex_to_7seg decoder. One digit is driven per
// refresh slot of REFRESH_DIV clocks, in a continuous round-robin 0..7.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   synchronous, active-high; clears all state
//   load         in   1   strobe: capture data_in into the display register
//   data_in      in   32  value to display; nibble i -> digit i (0 = rightmost)
//   lz_en        in   1   suppress leading zeros (digit 0 never suppressed)
//   digit_en     in   8   per-digit enable mask; 0 = digit always dark
//   hex          out  4   nibble to the shared decoder
//   anode        out  8   active-low digit enables, at most one low
//   frame_start  out  1   one-cycle pulse when digit 0 becomes the active slot

module display_scan_ctrl #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic        lz_en,
  input  logic [7:0]  digit_en,
  output logic [3:0]  hex,
  output logic [7:0]  anode,
  output logic        frame_start
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {
    BLANK = 1'b0,
    SCAN  = 1'b1
  } state_t;

  state_t        state;
  logic [31:0]   data_reg;
  logic [CW-1:0] div_cnt;
  logic [2:0]    digit_sel;

  logic          tick;
  logic [4:0]    bit_ofs;
  logic [31:0]   upper;
  logic          blank;

  assign tick = (div_cnt == CW'(REFRESH_DIV - 1));

  // digit_sel is held at 0 while BLANK, so it always names the digit of the
  // slot that the next tick will open.
  always_comb begin
    bit_ofs = {digit_sel, 2'b00};
    upper   = data_reg >> bit_ofs;
    blank   = !digit_en[digit_sel] ||
              (lz_en && (digit_sel != 3'd0) && (upper == 32'd0));
  end

  // Slot outputs are computed from the data_reg value before any coincident
  // load, so a load on a tick edge only shows from the following slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BLANK;
      data_reg    <= 32'd0;
      div_cnt     <= '0;
      digit_sel   <= 3'd0;
      hex         <= 4'd0;
      anode       <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      if (load) begin
        data_reg <= data_in;
      end

      div_cnt     <= tick ? '0 : div_cnt + 1'b1;
      frame_start <= 1'b0;

      if (tick) begin
        state       <= SCAN;
        hex         <= data_reg[bit_ofs +: 4];
        anode       <= blank ? 8'hFF : ~(8'b1 << digit_sel);
        digit_sel   <= digit_sel + 3'd1;
        frame_start <= (digit_sel == 3'd0);
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - self-checking bench for display_scan_ctrl

module tb_display_scan_ctrl;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic        lz_en = 1'b0;
  logic [7:0]  digit_en = 8'hFF;
  logic [3:0]  hex;
  logic [7:0]  anode;
  logic        frame_start;

  display_scan_ctrl #(.REFRESH_DIV(RD)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .data_in(data_in),
    .lz_en(lz_en),
    .digit_en(digit_en),
    .hex(hex),
    .anode(anode),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        lz;
    logic [7:0]  den;
    logic [31:0] exp_hex;
    logic [7:0]  exp_lit;
  } vec_t;

  typedef struct {
    logic [3:0] hex;
    logic [7:0] anode;
    logic       fs;
  } exp_t;

  localparam int NV = 6;
  vec_t vec [NV];
  exp_t q [$];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [3:0] h, input logic [7:0] a, input logic f);
    exp_t e;
    e.hex = h;
    e.anode = a;
    e.fs = f;
    q.push_back(e);
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got hex %h anode %h", name, hex, anode);
      return;
    end
    e = q.pop_front();
    check({name, " hex"}, 32'(hex), 32'(e.hex));
    check({name, " anode"}, 32'(anode), 32'(e.anode));
    check({name, " frame_start"}, 32'(frame_start), 32'(e.fs));
  endtask

  task automatic wait_frame();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_frame: frame_start got 0 expected 1 within 64 cycles");
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic lz, input logic [7:0] den);
    data_in = d;
    lz_en = lz;
    digit_en = den;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
  endtask

  task automatic check_blank(input string name);
    check({name, " anode"}, 32'(anode), 32'h0000_00FF);
    check({name, " hex"}, 32'(hex), 32'h0);
    check({name, " frame_start"}, 32'(frame_start), 32'h0);
  endtask

  // Common exit path after reset is released at a negedge: three more dark
  // cycles, then digit 0 lit with the cleared register value.
  task automatic check_restart(input string name);
    for (int i = 0; i < RD - 1; i++) begin
      step();
      check_blank({name, " dark"});
    end
    step();
    check({name, " first anode"}, 32'(anode), 32'h0000_00FE);
    check({name, " first hex"}, 32'(hex), 32'h0);
    check({name, " first frame_start"}, 32'(frame_start), 32'h1);
    step();
    check({name, " fs drop"}, 32'(frame_start), 32'h0);
    check({name, " anode hold"}, 32'(anode), 32'h0000_00FE);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] nib;
    logic [7:0] an;

    vec[0] = '{32'h8765_4321, 1'b0, 8'hFF, 32'h8765_4321, 8'hFF};
    vec[1] = '{32'h0000_00A0, 1'b1, 8'hFF, 32'h0000_00A0, 8'h03};
    vec[2] = '{32'h0000_0000, 1'b1, 8'hFF, 32'h0000_0000, 8'h01};
    vec[3] = '{32'hFFFF_FFFF, 1'b0, 8'h0F, 32'hFFFF_FFFF, 8'h0F};
    vec[4] = '{32'h0012_0000, 1'b1, 8'hFF, 32'h0012_0000, 8'h3F};
    vec[5] = '{32'h8765_4321, 1'b1, 8'hFE, 32'h8765_4321, 8'hFE};

    reset = 1'b1;
    repeat (3) step();
    check_blank("reset");
    reset = 1'b0;
    check_restart("post_reset");

    for (int v = 0; v < NV; v++) begin
      do_load(vec[v].data, vec[v].lz, vec[v].den);
      for (int d = 0; d < 8; d++) begin
        nib = vec[v].exp_hex[4*d +: 4];
        an = vec[v].exp_lit[d] ? ~(8'h01 << d) : 8'hFF;
        for (int k = 0; k < RD; k++) begin
          push_exp(nib, an, (d == 0) && (k == 0));
        end
      end
      wait_frame();
      pop_check($sformatf("vec%0d c0", v));
      for (int c = 1; c < 8 * RD; c++) begin
        step();
        pop_check($sformatf("vec%0d c%0d", v, c));
      end
      q.delete();
    end

    // Load on the tick edge that opens slot 1: old data for slot 1, new after.
    do_load(32'h1111_1111, 1'b0, 8'hFF);
    wait_frame();
    repeat (RD - 1) step();
    data_in = 32'h2222_2222;
    load = 1'b1;
    for (int k = 0; k < RD; k++) push_exp(4'h1, 8'hFD, 1'b0);
    push_exp(4'h2, 8'hFB, 1'b0);
    step();
    load = 1'b0;
    pop_check("tick_load s1 c0");
    for (int c = 1; c <= RD; c++) begin
      step();
      pop_check($sformatf("tick_load c%0d", c));
    end

    // Reset in the middle of digit 5's slot.
    wait_frame();
    repeat (5 * RD + 1) step();
    check("mid digit5 anode", 32'(anode), 32'h0000_00DF);
    check("mid digit5 hex", 32'(hex), 32'h2);
    reset = 1'b1;
    step();
    check_blank("mid_reset");
    reset = 1'b0;
    check_restart("rescan");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
